// File: rtl/eq_pkg.sv
// Shared types and constants for the equalizer LED effect blocks.
package eq_pkg;

  localparam int SAMPLE_W = 16;
  localparam int MAG_W    = 15;
  localparam int LED_W    = 8;

  // Peak thresholds for the four bar segments, lowest first.
  localparam logic [MAG_W-1:0] LVL1 = 15'd256;
  localparam logic [MAG_W-1:0] LVL2 = 15'd1024;
  localparam logic [MAG_W-1:0] LVL3 = 15'd4096;
  localparam logic [MAG_W-1:0] LVL4 = 15'd16384;

  typedef enum logic {
    SWEEP = 1'b0,
    METER = 1'b1
  } vu_state_t;

  // Thermometer code for a 4-segment bar: the lowest segment lights first.
  function automatic logic [3:0] thermo4(input logic [2:0] lvl);
    logic [3:0] bar;
    case (lvl)
      3'd0:    bar = 4'b0000;
      3'd1:    bar = 4'b0001;
      3'd2:    bar = 4'b0011;
      3'd3:    bar = 4'b0111;
      default: bar = 4'b1111;
    endcase
    return bar;
  endfunction

endpackage

// File: rtl/led_vu_meter_peak_tracker.sv
// Per-channel decaying peak detector with 0..4 level encode.
module peak_tracker
  import eq_pkg::*;
#(
  parameter int DECAY_SHIFT = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid,
  input  logic                       decay_step,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic [2:0]                 level
);

  logic [MAG_W-1:0] r_peak;
  logic [MAG_W-1:0] w_mag;
  logic [MAG_W-1:0] w_base;

  // |sample| in MAG_W bits; the most negative code saturates instead of wrapping to 0.
  function automatic logic [MAG_W-1:0] abs_sat(input logic signed [SAMPLE_W-1:0] s);
    logic [MAG_W-1:0] m;
    if (s == {1'b1, {(SAMPLE_W-1){1'b0}}})
      m = '1;
    else if (s[SAMPLE_W-1])
      m = MAG_W'(-s);
    else
      m = MAG_W'(s);
    return m;
  endfunction

  assign w_mag  = abs_sat(sample);
  // Decay is taken before the max so a loud sample in a decay cycle is kept intact.
  assign w_base = decay_step ? (r_peak - (r_peak >> DECAY_SHIFT)) : r_peak;

  // Peak register: updates only on valid, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_peak <= '0;
    else if (valid)
      r_peak <= (w_mag > w_base) ? w_mag : w_base;
  end

  // Level encode from the registered peak.
  always_comb begin
    level = 3'd0;
    if (r_peak >= LVL4)      level = 3'd4;
    else if (r_peak >= LVL3) level = 3'd3;
    else if (r_peak >= LVL2) level = 3'd2;
    else if (r_peak >= LVL1) level = 3'd1;
  end

endmodule

// File: rtl/led_vu_meter.sv
// Stereo VU meter on an 8-LED bank: power-on sweep, then left bar on
// LED[7:4] and right bar on LED[3:0], each driven by a decaying peak.
module led_vu_meter
  import eq_pkg::*;
#(
  parameter int DECAY_SAMPLES = 1024,
  parameter int DECAY_SHIFT   = 3,
  parameter int SWEEP_CYCLES  = 6250000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid,
  input  logic signed [SAMPLE_W-1:0] lft_out,
  input  logic signed [SAMPLE_W-1:0] rht_out,
  output logic [LED_W-1:0]           LED
);

  localparam int DCNT_W = $clog2(DECAY_SAMPLES);
  localparam int SCNT_W = (SWEEP_CYCLES > 1) ? $clog2(SWEEP_CYCLES) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECAY_SAMPLES - 1);
  localparam logic [SCNT_W-1:0] SCNT_LAST = SCNT_W'(SWEEP_CYCLES - 1);

  logic [DCNT_W-1:0] r_dcnt;
  logic [SCNT_W-1:0] r_scnt;
  logic [2:0]        r_sidx;
  vu_state_t         r_state;
  logic [LED_W-1:0]  r_led;
  logic              w_decay_step;
  logic [2:0]        w_lvl_l;
  logic [2:0]        w_lvl_r;

  assign w_decay_step = valid && (r_dcnt == DCNT_LAST);
  assign LED          = r_led;

  // Sample counter that paces the peak decay; explicit wrap allows any length.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_dcnt <= '0;
    else if (valid)
      r_dcnt <= w_decay_step ? '0 : r_dcnt + DCNT_W'(1);
  end

  peak_tracker #(
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_lft (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .decay_step (w_decay_step),
    .sample     (lft_out),
    .level      (w_lvl_l)
  );

  peak_tracker #(
    .DECAY_SHIFT (DECAY_SHIFT)
  ) u_rht (
    .clk        (clk),
    .rst_n      (rst_n),
    .valid      (valid),
    .decay_step (w_decay_step),
    .sample     (rht_out),
    .level      (w_lvl_r)
  );

  // Display FSM: one pass of a walking LED, then the two bar graphs forever.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SWEEP;
      r_scnt  <= '0;
      r_sidx  <= 3'd0;
      r_led   <= '0;
    end else begin
      case (r_state)
        SWEEP: begin
          r_led <= LED_W'(1) << r_sidx;
          if (r_scnt == SCNT_LAST) begin
            r_scnt <= '0;
            r_sidx <= r_sidx + 3'd1;
            if (r_sidx == 3'd7)
              r_state <= METER;
          end else begin
            r_scnt <= r_scnt + SCNT_W'(1);
          end
        end
        default: begin
          r_led <= {thermo4(w_lvl_l), thermo4(w_lvl_r)};
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_vu_meter.sv
// Scoreboard bench for led_vu_meter: stimulus queues timed expectations,
// a negedge monitor pops and compares them against LED and the peaks.
module tb_led_vu_meter;

  logic               clk     = 1'b0;
  logic               rst_n   = 1'b0;
  logic               valid   = 1'b0;
  logic signed [15:0] lft_out = '0;
  logic signed [15:0] rht_out = '0;
  logic [7:0]         LED;

  led_vu_meter #(
    .DECAY_SAMPLES (4),
    .DECAY_SHIFT   (3),
    .SWEEP_CYCLES  (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .lft_out (lft_out),
    .rht_out (rht_out),
    .LED     (LED)
  );

  always #10 clk = ~clk;

  // Edge count since the last reset release.
  int cyc = 0;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    int    due;
    int    kind;   // 0 = LED, 1 = left peak, 2 = right peak
    int    expv;
    string name;
  } chk_t;

  chk_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  task automatic push(input int due, input int kind, input int expv, input string name);
    chk_t it;
    it.due  = due;
    it.kind = kind;
    it.expv = expv;
    it.name = name;
    q.push_back(it);
  endtask

  function automatic int actual(input int kind);
    case (kind)
      1:       return int'(dut.u_lft.r_peak);
      2:       return int'(dut.u_rht.r_peak);
      default: return int'(LED);
    endcase
  endfunction

  // Monitor: compare every expectation whose cycle has come.
  initial begin
    chk_t it;
    int   act;
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].due <= cyc) begin
        it  = q.pop_front();
        act = actual(it.kind);
        checks++;
        if (it.due < cyc) begin
          errors++;
          $display("FAIL %s missed at cycle %0d (due %0d) actual %0d required %0d",
                   it.name, cyc, it.due, act, it.expv);
        end else if (act != it.expv) begin
          errors++;
          $display("FAIL %s actual 0x%0h required 0x%0h", it.name, act, it.expv);
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Issue one valid at the current negedge; peaks are due one edge later, LED two.
  task automatic send(input logic signed [15:0] l, input logic signed [15:0] r,
                      input bit chk, input int epl, input int epr, input int eled,
                      input int gap);
    int c;
    c = cyc;
    vec_id++;
    valid   = 1'b1;
    lft_out = l;
    rht_out = r;
    if (chk) begin
      push(c + 1, 1, epl,  $sformatf("v%0d_peak_l", vec_id));
      push(c + 1, 2, epr,  $sformatf("v%0d_peak_r", vec_id));
      push(c + 2, 0, eled, $sformatf("v%0d_led", vec_id));
    end
    @(negedge clk);
    valid   = 1'b0;
    lft_out = '0;
    rht_out = '0;
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    // Reset state and the full power-on sweep.
    push(0, 0, 0, "reset_led");
    push(0, 1, 0, "reset_peak_l");
    push(0, 2, 0, "reset_peak_r");
    for (int k = 1; k <= 32; k++)
      push(k, 0, 1 << ((k - 1) / 4), $sformatf("sweep_%0d", k));
    push(33, 0, 0, "meter_idle");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(34);

    // Level encode, saturation of -32768, consecutive valids.
    send(16'sd300,   -16'sd20000, 1, 300,   20000, 8'h1F, 0);
    send(16'sd0,     16'sh8000,   1, 300,   32767, 8'h1F, 0);
    send(16'sd20000, 16'sd0,      1, 20000, 32767, 8'hFF, 0);
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-meter, between clock edges.
    #3 rst_n = 1'b0;
    #1;
    push(0, 0, 0, "midrst_led");
    push(0, 1, 0, "midrst_peak_l");
    push(0, 2, 0, "midrst_peak_r");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push(1,  0, 8'h01, "resweep_1");
    push(4,  0, 8'h01, "resweep_4");
    push(5,  0, 8'h02, "resweep_5");
    push(32, 0, 8'h80, "resweep_32");
    push(33, 0, 8'h00, "resweep_meter");
    wait_cyc(34);
    push(35, 1, 0, "post_rst_peak_l");
    push(35, 2, 0, "post_rst_peak_r");
    @(negedge clk);

    // Decay chain: 16384 -> 14336 -> 12544 -> 10976 at every 4th valid.
    send(16'sd16384, 16'sd0, 1, 16384, 0, 8'hF0, 1);
    send(16'sd0, 16'sd0, 0, 0, 0, 0, 0);
    send(16'sd0, 16'sd0, 0, 0, 0, 0, 2);
    send(16'sd0, 16'sd0, 1, 14336, 0, 8'h70, 1);
    for (int i = 0; i < 3; i++) send(16'sd0, 16'sd0, 0, 0, 0, 0, 0);
    send(16'sd0, 16'sd0, 1, 12544, 0, 8'h70, 1);
    for (int i = 0; i < 3; i++) send(16'sd0, 16'sd0, 0, 0, 0, 0, 1);
    send(16'sd0, 16'sd0, 1, 10976, 0, 8'h70, 0);
    for (int i = 0; i < 3; i++) send(16'sd0, 16'sd0, 0, 0, 0, 0, 0);
    // Decay step and new max on both channels at once: decayed 9604 loses to 14000.
    send(16'sd14000, -16'sd5000, 1, 14000, 5000, 8'h77, 2);
    push(cyc + 5, 1, 14000, "hold_peak_l");
    push(cyc + 5, 2, 5000,  "hold_peak_r");
    push(cyc + 5, 0, 8'h77, "hold_led");

    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      $display("FAIL drain %0d expectations never checked, required 0", q.size());
      errors += q.size();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
